// File: rtl/dmem_pkg.sv
// Shared types for the data-memory responder: request/response records and width constants.
package dmem_pkg;

  localparam int DATA_W = 32;
  localparam int BE_W   = DATA_W / 8;

  typedef struct packed {
    logic [DATA_W-1:0] rdata;
    logic              err;
  } rsp_t;

  typedef struct packed {
    logic              we;
    logic [31:0]       addr;
    logic [DATA_W-1:0] wdata;
    logic [BE_W-1:0]   be;
  } req_t;

endpackage

// File: rtl/dmem_rsp_fifo.sv
// In-order response FIFO; occupancy is tracked by a separate count so full/empty never
// depend on pointer comparison. Pointers wrap modulo DEPTH (need not be a power of two).
module dmem_rsp_fifo
  import dmem_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_wr_en,
  input  rsp_t             i_wr_data,
  input  logic             i_rd_en,
  output rsp_t             o_rd_data,
  output logic [CNT_W-1:0] o_count
);

  rsp_t             r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (i_wr_en) r_mem[r_wr_ptr] <= i_wr_data;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_wr_en) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (i_rd_en) r_rd_ptr <= ptr_inc(r_rd_ptr);
      case ({i_wr_en, i_rd_en})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Empty FIFO presents zeros so the response bus reads 0 out of reset.
  assign o_rd_data = (r_count != '0) ? r_mem[r_rd_ptr] : '0;
  assign o_count   = r_count;

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: word RAM behind valid/ready request and response channels with a
// fixed LATENCY and an in-order response FIFO. Define DMEM_RANGE_CHECK_EN to flag out-of-range addresses.
module dmem_responder #(
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 32,
  parameter int LATENCY   = 2,
  parameter int RSP_DEPTH = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [31:0]         req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_be,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err
);
  import dmem_pkg::*;

  localparam int CNT_W = $clog2(RSP_DEPTH + 1);
  localparam int WORDS = 1 << ADDR_W;

  req_t                     w_req;
  logic                     w_accept;
  logic                     w_fire;
  logic                     w_range_ok;
  logic                     w_unused;
  logic [ADDR_W-1:0]        w_idx;
  logic [CNT_W-1:0]         r_outstanding;
  logic [DATA_W-1:0]        r_mem [WORDS];
  logic [DATA_W-1:0]        r_rd_data;
  logic                     r_s0_valid;
  logic                     r_s0_zero;
  logic                     r_s0_err;
  logic [DATA_W-1:0]        w_s0_rdata;
  logic [LATENCY-1:0]       w_pipe_valid;
  rsp_t [LATENCY-1:0]       w_pipe_rsp;
  rsp_t                     w_fifo_rd;
  logic [CNT_W-1:0]         w_fifo_count;

  assign w_req    = '{we: req_we, addr: req_addr, wdata: req_wdata, be: req_be};
  assign w_idx    = w_req.addr[ADDR_W+1:2];
  assign w_accept = req_valid & req_ready;
  assign w_fire   = rsp_valid & rsp_ready;

`ifdef DMEM_RANGE_CHECK_EN
  assign w_range_ok = (w_req.addr[31:ADDR_W+2] == '0);
  assign rsp_err    = w_fifo_rd.err;
  assign w_unused   = ^w_req.addr[1:0];
`else
  assign w_range_ok = 1'b1;
  assign rsp_err    = 1'b0;
  assign w_unused   = ^{w_req.addr[31:ADDR_W+2], w_req.addr[1:0], w_fifo_rd.err};
`endif

  // The counter bounds outstanding requests to the FIFO depth, so the pipe never stalls.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_outstanding <= '0;
    end else if (w_accept && !w_fire) begin
      r_outstanding <= r_outstanding + CNT_W'(1);
    end else if (!w_accept && w_fire) begin
      r_outstanding <= r_outstanding - CNT_W'(1);
    end
  end

  assign req_ready = reset_n & (r_outstanding < CNT_W'(RSP_DEPTH));

  always_ff @(posedge clk) begin
    if (w_accept && w_req.we && w_range_ok) begin
      for (int b = 0; b < DATA_W / 8; b++) begin
        if (w_req.be[b]) r_mem[w_idx][b*8 +: 8] <= w_req.wdata[b*8 +: 8];
      end
    end
    if (w_accept && !w_req.we) r_rd_data <= r_mem[w_idx];
  end

  // The RAM read register is the first latency stage; stores and errors zero the data there.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_s0_valid <= 1'b0;
      r_s0_zero  <= 1'b0;
      r_s0_err   <= 1'b0;
    end else begin
      r_s0_valid <= w_accept;
      r_s0_zero  <= w_req.we | ~w_range_ok;
      r_s0_err   <= ~w_range_ok;
    end
  end

  assign w_s0_rdata      = r_s0_zero ? '0 : r_rd_data;
  assign w_pipe_valid[0] = r_s0_valid;
  assign w_pipe_rsp[0]   = '{rdata: w_s0_rdata, err: r_s0_err};

  genvar gi;
  generate
    for (gi = 1; gi < LATENCY; gi++) begin : g_stage
      logic r_valid;
      rsp_t r_rsp;
      always_ff @(posedge clk) begin
        if (!reset_n) begin
          r_valid <= 1'b0;
          r_rsp   <= '0;
        end else begin
          r_valid <= w_pipe_valid[gi-1];
          r_rsp   <= w_pipe_rsp[gi-1];
        end
      end
      assign w_pipe_valid[gi] = r_valid;
      assign w_pipe_rsp[gi]   = r_rsp;
    end
  endgenerate

  dmem_rsp_fifo #(.DEPTH(RSP_DEPTH)) u_rsp_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .i_wr_en   (w_pipe_valid[LATENCY-1]),
    .i_wr_data (w_pipe_rsp[LATENCY-1]),
    .i_rd_en   (w_fire),
    .o_rd_data (w_fifo_rd),
    .o_count   (w_fifo_count)
  );

  assign rsp_valid = (w_fifo_count != '0);
  assign rsp_rdata = w_fifo_rd.rdata;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed scenarios plus random traffic against a queue/array
// reference model. Honours DMEM_RANGE_CHECK_EN when the macro is defined for the build.
module tb_dmem_responder;

  localparam int ADDR_W    = 8;
  localparam int DATA_W    = 32;
  localparam int LATENCY   = 2;
  localparam int RSP_DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  always #5 clk = ~clk;

  dmem_responder #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LATENCY(LATENCY), .RSP_DEPTH(RSP_DEPTH)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_be    (req_be),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err)
  );

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          acc_edge;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] ref_mem [1 << ADDR_W];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          edge_n = 0;
  int          n_rsp = 0;
  logic [31:0] last_rdata;
  logic        last_err;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (edge %0d)", tag, got, want, edge_n);
    end
  endtask

  function automatic logic range_err(input logic [31:0] a);
`ifdef DMEM_RANGE_CHECK_EN
    return (a >> (ADDR_W + 2)) != 0;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] be);
    logic [31:0] mask;
    mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    return (old & ~mask) | (d & mask);
  endfunction

  // One clock cycle: drive inputs, check outputs against the model, update the model.
  task automatic step(input logic v, input logic we, input logic [31:0] a,
                      input logic [31:0] d, input logic [3:0] be, input logic rr);
    logic              exp_rdy;
    logic              exp_vld;
    logic [ADDR_W-1:0] idx;
    exp_t              e;
    req_valid = v; req_we = we; req_addr = a; req_wdata = d; req_be = be; rsp_ready = rr;
    #1;
    exp_rdy = reset_n && (exp_q.size() < RSP_DEPTH);
    exp_vld = (exp_q.size() > 0) && (edge_n - exp_q[0].acc_edge >= LATENCY);
    chk("req_ready", {63'd0, req_ready}, {63'd0, exp_rdy});
    chk("rsp_valid", {63'd0, rsp_valid}, {63'd0, exp_vld});
    if (exp_vld) begin
      chk("rsp_data", {31'd0, rsp_err, rsp_rdata}, {31'd0, exp_q[0].err, exp_q[0].rdata});
      if (rr) begin
        $display("rsp %0d: rdata=%h err=%b edge=%0d", n_rsp, rsp_rdata, rsp_err, edge_n);
        last_rdata = rsp_rdata;
        last_err   = rsp_err;
        n_rsp++;
        void'(exp_q.pop_front());
      end
    end
    if (v && exp_rdy) begin
      idx        = a[ADDR_W+1:2];
      e.err      = range_err(a);
      e.acc_edge = edge_n + 1;
      if (we) begin
        e.rdata = 32'd0;
        if (!e.err) ref_mem[idx] = merge(ref_mem[idx], d, be);
      end else begin
        e.rdata = e.err ? 32'd0 : ref_mem[idx];
      end
      exp_q.push_back(e);
    end
    @(posedge clk);
    edge_n++;
    if (!reset_n) exp_q.delete();
    @(negedge clk);
  endtask

  task automatic idle(input logic rr);
    step(1'b0, 1'b0, 32'd0, 32'd0, 4'd0, rr);
  endtask

  task automatic drain();
    repeat (LATENCY + RSP_DEPTH + 2) idle(1'b1);
    chk("drain_empty", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    logic [31:0] a;
    reset_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
    req_wdata = '0; req_be = '0; rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    chk("reset_rsp_rdata", {32'd0, rsp_rdata}, 64'd0);
    chk("reset_rsp_err", {63'd0, rsp_err}, 64'd0);
    chk("reset_req_ready", {63'd0, req_ready}, 64'd0);
    reset_n = 1'b1;

    // Fill every word so later loads have defined contents.
    for (int i = 0; i < (1 << ADDR_W); i++) step(1'b1, 1'b1, 32'(i) << 2, $urandom, 4'hF, 1'b1);
    drain();

    step(1'b1, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 1'b1);
    step(1'b1, 1'b0, 32'h10, 32'd0, 4'h0, 1'b1);
    drain();
    chk("t1_load", {32'd0, last_rdata}, {32'd0, 32'hDEADBEEF});

    step(1'b1, 1'b1, 32'h10, 32'h11223344, 4'b0101, 1'b1);
    step(1'b1, 1'b0, 32'h10, 32'd0, 4'h0, 1'b1);
    drain();
    chk("t2_partial", {32'd0, last_rdata}, {32'd0, 32'hDE22BE44});
    step(1'b1, 1'b1, 32'h10, 32'hFFFFFFFF, 4'b0000, 1'b1);
    step(1'b1, 1'b0, 32'h10, 32'd0, 4'h0, 1'b1);
    drain();
    chk("t2_be_zero", {32'd0, last_rdata}, {32'd0, 32'hDE22BE44});

    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 32'(i) << 2, 32'd0, 4'h0, 1'b0);
    chk("t3_full_ready", {63'd0, req_ready}, 64'd0);
    drain();

    step(1'b1, 1'b1, 32'h404, $urandom, 4'hF, 1'b1);
    step(1'b1, 1'b0, 32'h400, 32'd0, 4'h0, 1'b1);
    step(1'b1, 1'b0, 32'h004, 32'd0, 4'h0, 1'b1);
    step(1'b1, 1'b0, 32'h400, 32'd0, 4'h0, 1'b1);
    drain();
`ifdef DMEM_RANGE_CHECK_EN
    chk("t4_range", {31'd0, last_err, last_rdata}, {31'd0, 1'b1, 32'd0});
`else
    chk("t4_alias", {31'd0, last_err, last_rdata}, {31'd0, 1'b0, ref_mem[0]});
`endif

    step(1'b1, 1'b1, 32'h20, 32'hCAFEF00D, 4'hF, 1'b1);
    reset_n = 1'b0;
    idle(1'b1);
    reset_n = 1'b1;
    chk("t5_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    chk("t5_rsp_rdata", {32'd0, rsp_rdata}, 64'd0);
    repeat (4) idle(1'b1);
    step(1'b1, 1'b0, 32'h20, 32'd0, 4'h0, 1'b1);
    drain();
    chk("t5_committed", {32'd0, last_rdata}, {32'd0, 32'hCAFEF00D});

    for (int i = 0; i < 16; i++) begin
      if (i % 2 == 0) step(1'b1, 1'b1, 32'h100 + 32'(i) * 4, $urandom, 4'hF, 1'b1);
      else            step(1'b1, 1'b0, 32'h200 + 32'(i) * 4, 32'd0, 4'h0, 1'b1);
    end
    drain();

    for (int i = 0; i < 400; i++) begin
      a = 32'($urandom_range(0, 15)) << 2;
      if ($urandom_range(0, 7) == 0) a = a | (32'h400 * 32'($urandom_range(1, 3)));
      if (i == 200) reset_n = 1'b0;
      step($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), a, $urandom,
           4'($urandom_range(0, 15)), $urandom_range(0, 3) != 0);
      reset_n = 1'b1;
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
